// File: rtl/simon_pkg.sv
// Shared Simon display definitions: active-low seven-segment patterns, blank code,
// display-mode encodings, default dividers and a BCD increment helper.
package simon_pkg;

    localparam int DEF_REFRESH_DIV = 100000;
    localparam int DEF_BLINK_DIV   = 250;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index = decimal digit; bit0 = segment a ... bit6 = segment g, low = lit.
    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef enum logic [1:0] {
        SHOW      = 2'd0,
        BLINK_ON  = 2'd1,
        BLINK_OFF = 2'd2
    } disp_mode_e;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment pattern, with blank override.
module seg7_decode
    import simon_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank && bcd <= 4'd9) seg = SEG_DIGITS[bcd];
    end

endmodule

// File: rtl/score_display.sv
// BCD score counter with multiplexed 4-digit seven-segment drive and error blink.
// Optional best-score register and show_best port when SCORE_BEST_EN is defined.
module score_display
    import simon_pkg::*;
#(
    parameter int REFRESH_DIV = DEF_REFRESH_DIV,
    parameter int BLINK_DIV   = DEF_BLINK_DIV
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        round_ok,
    input  logic        game_over,
    input  logic        clear,
`ifdef SCORE_BEST_EN
    input  logic        show_best,
`endif
    output logic [15:0] score,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int NUM_DIGITS = 4;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [RW-1:0]                   ref_cnt;
    logic                            tick;
    logic [1:0]                      dig_idx, dig_nxt;
    logic [BW-1:0]                   blink_cnt;
    logic                            blink_wrap;
    disp_mode_e                      mode, mode_nxt;
    logic [15:0]                     disp_val;
    logic [NUM_DIGITS-1:0]           blank;
    logic [NUM_DIGITS-1:0][6:0]      dig_seg;

    assign tick       = (ref_cnt == RW'(REFRESH_DIV - 1));
    assign dig_nxt    = tick ? dig_idx + 2'd1 : dig_idx;
    assign blink_wrap = game_over && tick && (blink_cnt == BW'(BLINK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score <= 16'h0000;
        end else if (clear) begin
            score <= 16'h0000;
        end else if (!game_over && round_ok && score != 16'h9999) begin
            score <= bcd_inc(score);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_cnt <= '0;
            dig_idx <= 2'd0;
        end else begin
            ref_cnt <= tick ? '0 : ref_cnt + RW'(1);
            dig_idx <= dig_nxt;
        end
    end

    // Blink counter only runs while the error state is held; dropping it restarts the phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
        end else if (!game_over) begin
            blink_cnt <= '0;
        end else if (tick) begin
            blink_cnt <= blink_wrap ? '0 : blink_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mode <= SHOW;
        else        mode <= mode_nxt;
    end

    always_comb begin
        mode_nxt = mode;
        case (mode)
            SHOW:      if (game_over) mode_nxt = BLINK_ON;
            BLINK_ON:  if (!game_over) mode_nxt = SHOW;
                       else if (blink_wrap) mode_nxt = BLINK_OFF;
            BLINK_OFF: if (!game_over) mode_nxt = SHOW;
                       else if (blink_wrap) mode_nxt = BLINK_ON;
            default:   mode_nxt = SHOW;
        endcase
    end

`ifdef SCORE_BEST_EN
    logic [15:0] best;
    logic        go_d;

    // BCD digits are ordered, so a plain magnitude compare ranks scores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best <= 16'h0000;
            go_d <= 1'b0;
        end else begin
            go_d <= game_over;
            if (game_over && !go_d && score > best) best <= score;
        end
    end

    assign disp_val = show_best ? best : score;
`else
    assign disp_val = score;
`endif

    always_comb begin
        logic lead;
        lead  = 1'b1;
        blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lead     = lead && (disp_val[4*i +: 4] == 4'd0);
            blank[i] = lead;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
        seg7_decode u_dec (
            .bcd   (disp_val[4*i +: 4]),
            .blank (blank[i]),
            .seg   (dig_seg[i])
        );
    end

    // Outputs are registered from next-cycle state so a new slot or blink phase lands one cycle after its tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= SEG_BLANK;
            an  <= 4'hF;
        end else begin
            seg <= dig_seg[dig_nxt];
            an  <= (mode_nxt == BLINK_OFF) ? 4'hF : ~(4'b0001 << dig_nxt);
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display: directed scenarios plus random traffic
// against an arithmetic model of score, scan slot, blink phase and best score.
module tb_score_display;

    localparam int R = 4;
    localparam int B = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        round_ok, game_over, clear, show_best;
    logic [15:0] score;
    logic [6:0]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;

    // Model state
    int sc_m, best_m, n_edges, gticks;
    bit go_prev;

    logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    score_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .round_ok  (round_ok),
        .game_over (game_over),
        .clear     (clear),
`ifdef SCORE_BEST_EN
        .show_best (show_best),
`endif
        .score     (score),
        .seg       (seg),
        .an        (an)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input int v, input int d);
        int p = 1;
        for (int i = 0; i < d; i++) p *= 10;
        if (d > 0 && v < p) return 7'h7F;
        return pat[(v / p) % 10];
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sc_m = 0; best_m = 0; n_edges = 0; gticks = 0; go_prev = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, compare just after it.
    task automatic step(input logic ro, input logic go, input logic clr, input logic sb);
        int dv, idx;
        logic [6:0] es;
        logic [3:0] ea;
        round_ok = ro; game_over = go; clear = clr; show_best = sb;
        @(posedge clk);
        n_edges++;
`ifdef SCORE_BEST_EN
        dv = sb ? best_m : sc_m;
`else
        dv = sc_m;
`endif
        idx = (n_edges / R) % 4;
        if (go) begin
            if (n_edges % R == 0) gticks++;
        end else begin
            gticks = 0;
        end
        es = exp_seg(dv, idx);
        ea = ((gticks / B) % 2 == 1) ? 4'hF : ~(4'b0001 << idx);
        if (go && !go_prev && sc_m > best_m) best_m = sc_m;
        go_prev = go;
        if (clr) sc_m = 0;
        else if (!go && ro && sc_m < 9999) sc_m++;
        #1;
        chk("an", {12'h0, an}, {12'h0, ea});
        chk("seg", {9'h0, seg}, {9'h0, es});
        chk("score", score, to_bcd(sc_m));
        @(negedge clk);
    endtask

    initial begin
        bit found;
        bit g, s;
        reset = 1'b0; round_ok = 0; game_over = 0; clear = 0; show_best = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_score", score, 16'h0000);

        reset = 1'b1;
        step(0, 0, 0, 0);
        chk("first_an", {12'h0, an}, 16'h000E);
        chk("first_seg", {9'h0, seg}, 16'h0040);
        repeat (16) step(0, 0, 0, 0);

        // Decimal carry
        repeat (10) step(1, 0, 0, 0);
        chk("carry", score, 16'h0010);
        repeat (16) step(0, 0, 0, 0);

        // Priority
        step(1, 0, 1, 0);
        chk("clr_over_ro", score, 16'h0000);
        repeat (3) step(1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        chk("frozen_go", score, 16'h0003);
        step(1, 1, 1, 0);
        chk("clr_in_go", score, 16'h0000);

        // Blink and exit
        repeat (5) step(1, 0, 0, 0);
        repeat (24) step(0, 1, 0, 0);
        repeat (9) step(0, 0, 0, 0);

`ifdef SCORE_BEST_EN
        step(0, 0, 1, 0);
        repeat (5) step(1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        repeat (3) step(1, 0, 0, 0);
        repeat (3) step(0, 1, 0, 0);
        found = 0;
        for (int k = 0; k < 32 && !found; k++) begin
            step(0, 1, 0, 1);
            if (an == 4'hE) found = 1;
        end
        chk("best_found", {15'h0, found}, 16'h0001);
        if (found) chk("best_seg", {9'h0, seg}, 16'h0012);
        repeat (8) step(0, 0, 0, 1);
        repeat (4) step(0, 0, 0, 0);
`endif

        // Saturation
        step(0, 0, 1, 0);
        repeat (9999) step(1, 0, 0, 0);
        chk("sat_9999", score, 16'h9999);
        step(1, 0, 0, 0);
        chk("sat_hold", score, 16'h9999);
        repeat (16) step(0, 0, 0, 0);

        // Reset mid-operation
        repeat (6) step(1, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_score", score, 16'h0000);
        chk("mid_rst_an", {12'h0, an}, 16'h000F);
        chk("mid_rst_seg", {9'h0, seg}, 16'h007F);
        model_reset();
        @(negedge clk);
        round_ok = 0; game_over = 0; clear = 0; show_best = 0;
        reset = 1'b1;

        // Random traffic
        g = 0; s = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(39) == 0) g = ~g;
`ifdef SCORE_BEST_EN
            if ($urandom_range(49) == 0) s = ~s;
`endif
            step(1'($urandom_range(2) == 0), g, 1'($urandom_range(99) == 0), s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
